// File: rtl/seq_shift_divider.sv
// seq_shift_divider
// Multi-cycle restoring divider for the ALU DIV/REM path. Each CALC cycle
// shifts the {remainder, quotient} pair left by one bit and subtracts the
// divisor whenever the trial difference stays non-negative.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   start_i         request pulse, only sampled while idle
//   signed_i        1 = two's-complement operands, 0 = unsigned
//   dividend_i      dividend, sampled with start_i
//   divisor_i       divisor, sampled with start_i
//   busy_o          high while an operation is in progress (CALC and FIX)
//   done_o          one-cycle pulse, results valid
//   quotient_o      quotient, held until the next done_o
//   remainder_o     remainder, held until the next done_o
//   div_zero_o      divisor was zero, updated with done_o and held
module seq_shift_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_zero_o
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t           state_q,     state_d;
    logic [CW-1:0]    count_q,     count_d;
    logic [WIDTH-1:0] rem_q,       rem_d;
    logic [WIDTH-1:0] quo_q,       quo_d;
    logic [WIDTH-1:0] dvs_q,       dvs_d;
    logic             q_neg_q,     q_neg_d;
    logic             r_neg_q,     r_neg_d;
    logic             dz_pend_q,   dz_pend_d;
    logic             done_q,      done_d;
    logic [WIDTH-1:0] quotient_q,  quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_zero_q,  div_zero_d;

    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic             is_zero;
    logic             is_ovf;
    logic [WIDTH:0]   r_shifted;
    logic [WIDTH:0]   trial;

    // Operand preparation. The remainder never exceeds the divisor, so the
    // stored remainder fits WIDTH bits; only the shifted value and the trial
    // subtraction need the extra bit, which keeps unsigned divisors with the
    // MSB set correct.
    always_comb begin
        dvd_neg   = signed_i & dividend_i[WIDTH-1];
        dvs_neg   = signed_i & divisor_i[WIDTH-1];
        dvd_mag   = dvd_neg ? (~dividend_i + 1'b1) : dividend_i;
        dvs_mag   = dvs_neg ? (~divisor_i + 1'b1) : divisor_i;
        is_zero   = (divisor_i == '0);
        is_ovf    = signed_i && (dividend_i == {1'b1, {(WIDTH-1){1'b0}}})
                    && (divisor_i == '1);
        r_shifted = {rem_q, quo_q[WIDTH-1]};
        trial     = r_shifted - {1'b0, dvs_q};
    end

    // Next-state logic. Special cases load their final result straight into
    // the quotient/remainder pair with the sign flags cleared, so FIX applies
    // the same correction path to every operation.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        dz_pend_d   = dz_pend_q;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    count_d = '0;
                    dvs_d   = dvs_mag;
                    if (is_zero) begin
                        quo_d     = '1;
                        rem_d     = dividend_i;
                        q_neg_d   = 1'b0;
                        r_neg_d   = 1'b0;
                        dz_pend_d = 1'b1;
                        state_d   = FIX;
                    end else if (is_ovf) begin
                        quo_d     = {1'b1, {(WIDTH-1){1'b0}}};
                        rem_d     = '0;
                        q_neg_d   = 1'b0;
                        r_neg_d   = 1'b0;
                        dz_pend_d = 1'b0;
                        state_d   = FIX;
                    end else begin
                        quo_d     = dvd_mag;
                        rem_d     = '0;
                        q_neg_d   = dvd_neg ^ dvs_neg;
                        r_neg_d   = dvd_neg;
                        dz_pend_d = 1'b0;
                        state_d   = CALC;
                    end
                end
            end
            CALC: begin
                // Restoring step: keep the trial difference only if its sign
                // bit is clear, otherwise keep the shifted remainder.
                if (!trial[WIDTH]) begin
                    rem_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = r_shifted[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                count_d = count_q + 1'b1;
                if (count_q == CW'(WIDTH-1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                quotient_d  = q_neg_q ? (~quo_q + 1'b1) : quo_q;
                remainder_d = r_neg_q ? (~rem_q + 1'b1) : rem_q;
                div_zero_d  = dz_pend_q;
                done_d      = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All state and outputs are registered; reset abandons any operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            dz_pend_q   <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            dz_pend_q   <= dz_pend_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
        end
    end

    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;
    assign quotient_o  = quotient_q;
    assign remainder_o = remainder_q;
    assign div_zero_o  = div_zero_q;

endmodule
